pe_dot_accum_sched: RTL
=======================

Name: pe_dot_accum_sched

Overview:
Sequencer for the PE dot-product datapath (multipliers plus pipelined adder tree). Accepts a job command giving the number of DOT_SIZE-wide chunks and gates chunk beats into the datapath. Tracks the datapath's fixed pipeline latency with a valid shift register and accumulates each returned partial dot result into a wide signed accumulator. Presents the final sum on a valid/ready output port. One job is in flight at a time.

Parameters:
DOT_OUTPUT_WIDTH, 24, width of the signed datapath result dp_result
ACC_WIDTH, 32, width of the signed accumulator and out_data; must be >= DOT_OUTPUT_WIDTH
DP_LATENCY, 4, cycles from dp_issue to the matching dp_result; must be >= 1
CHUNK_W, 8, width of the chunk count; maximum job is 2^CHUNK_W-1 chunks

Ports:
clock  in  1  single clock
resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  job command valid
cmd_ready  out  1  high in IDLE only
cmd_num_chunks  in  CHUNK_W  chunks in the job; 0 is legal
in_valid  in  1  upstream operand chunk valid
in_ready  out  1  chunk accepted when in_valid&&in_ready
dp_issue  out  1  datapath operand-capture enable; equals in_valid&&in_ready
dp_result  in  DOT_OUTPUT_WIDTH  signed datapath result
out_valid  out  1  final sum valid
out_ready  in  1  downstream accepts the sum
out_data  out  ACC_WIDTH  signed accumulated dot product
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, resetn=0): state=IDLE; cmd_ready=1; in_ready=0; dp_issue=0; out_valid=0; out_data=0; busy=0; accumulator, counters and the valid pipe are all cleared. Reset mid-job discards the job, and results still in the datapath are ignored because the pipe is cleared.
- States: IDLE, FEED, DRAIN, OUT.
- IDLE: on cmd_valid, latch N=cmd_num_chunks, clear acc, issued_cnt and recv_cnt. If N==0, go to OUT with out_data=0. Otherwise go to FEED.
- FEED: in_ready=1 combinationally. Each handshake increments issued_cnt and shifts a 1 into the valid pipe. Once issued_cnt reaches N, in_ready=0 from the next cycle and the state goes to DRAIN. If a handshake occurs with issued_cnt==N-1, the FEED->DRAIN transition happens that same cycle.
- Valid pipe: DP_LATENCY-deep shift register, shifting every cycle and inserting dp_issue. A tail bit of 1 means dp_result is valid this cycle.
- On a tail bit of 1 (in FEED or DRAIN): acc <= acc + sign_extend(dp_result) at ACC_WIDTH, with two's-complement wrap; recv_cnt++.
- DRAIN: when recv_cnt reaches N (counting the current cycle's add), register out_data=acc_next and out_valid=1 next cycle, then go to OUT.
- Sum latency: out_valid rises DP_LATENCY+1 cycles after the last chunk handshake.
- OUT: out_valid=1. out_data stays stable while out_valid && !out_ready. On out_ready, go to IDLE next cycle, where out_valid=0 and cmd_ready=1.
- Back-to-back jobs: minimum one IDLE cycle between jobs.
- Input gaps: in_valid may drop at any time in FEED; there is no issue and no penalty.
- Commands presented outside IDLE are not accepted, because cmd_ready=0.
- dp_result is sampled only on tail-bit cycles; all other values are don't-care.

Optional Feature:
PE_DOT_SCHED_SAT_EN. When defined, the accumulate is saturating: on signed overflow, acc clamps to +(2^(ACC_WIDTH-1)-1) or -2^(ACC_WIDTH-1) and stays clamped for the rest of the job. A sticky output port sat_flag (1 bit, reset 0) is added; it is cleared at job start and valid alongside out_valid. When undefined, the add wraps in two's complement and there is no sat_flag port.

Test Plan:
- Reset: assert resetn=0 mid-FEED with 3 chunks issued -> all outputs are at reset values immediately. After release, a new job N=1 with dp_result=5 gives out_data=5 and no residue from the prior job.
- Basic job: N=4 with in_valid held high and dp_result 10, -3, 7, 100 -> in_ready high for exactly 4 cycles, out_valid DP_LATENCY+1 cycles after the 4th handshake, out_data=114.
- Gapped input plus backpressure: N=3 with in_valid toggled 1,0,1,0,1 and out_ready held low for 5 cycles -> dp_issue exactly 3 times, out_data=sum held stable, IDLE reached one cycle after out_ready=1.
- Zero-length job: cmd_num_chunks=0 -> no dp_issue, out_valid with out_data=0 within 2 cycles.
- Wrap/saturate: ACC_WIDTH=DOT_OUTPUT_WIDTH=8, N=2, dp_result 100 and 100 -> without the macro out_data=-56; with PE_DOT_SCHED_SAT_EN out_data=127 and sat_flag=1.
- Max length: N=255 with dp_result=-1 each -> out_data=-255 and the counters do not wrap early.

Source files
------------

// File: rtl/pe_dot_accum_sched.sv
// Job sequencer for the PE dot-product datapath: gates chunk beats in, tracks pipeline latency, accumulates partial results.
// Optional saturating accumulate with sticky sat_flag port when PE_DOT_SCHED_SAT_EN is defined.
module pe_dot_accum_sched #(
  parameter int DOT_OUTPUT_WIDTH = 24,
  parameter int ACC_WIDTH        = 32,
  parameter int DP_LATENCY       = 4,
  parameter int CHUNK_W          = 8
) (
  input  logic                               clock,
  input  logic                               resetn,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [CHUNK_W-1:0]                 cmd_num_chunks,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic                               dp_issue,
  input  logic signed [DOT_OUTPUT_WIDTH-1:0] dp_result,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic signed [ACC_WIDTH-1:0]        out_data,
  output logic                               busy
`ifdef PE_DOT_SCHED_SAT_EN
  ,
  output logic                               sat_flag
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]                  state;
  logic [CHUNK_W-1:0]          num_chunks;
  logic [CHUNK_W-1:0]          issued_cnt;
  logic [CHUNK_W-1:0]          recv_cnt;
  logic [CHUNK_W-1:0]          issued_next;
  logic [CHUNK_W-1:0]          recv_next;
  logic [DP_LATENCY-1:0]       valid_pipe;
  logic                        tail;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic signed [ACC_WIDTH-1:0] dp_ext;
  logic signed [ACC_WIDTH-1:0] sum_wrap;
  logic                        sat;
  logic                        sat_next;

  assign cmd_ready = (state == S_IDLE);
  assign in_ready  = (state == S_FEED);
  assign dp_issue  = in_valid && in_ready;
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_OUT);

  // A set tail bit marks the cycle on which dp_result belongs to an issued chunk.
  assign tail        = valid_pipe[DP_LATENCY-1];
  assign issued_next = issued_cnt + CHUNK_W'(1);
  assign recv_next   = recv_cnt + CHUNK_W'(1);
  assign dp_ext      = ACC_WIDTH'(dp_result);
  assign sum_wrap    = acc + dp_ext;

`ifdef PE_DOT_SCHED_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  assign sat_flag = sat;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    acc_next = acc;
    sat_next = sat;
    if (!sat) begin
      // Overflow only when both operands share a sign and the sum's sign differs; once clamped, hold for the job.
      if ((acc[ACC_WIDTH-1] == dp_ext[ACC_WIDTH-1]) && (sum_wrap[ACC_WIDTH-1] != acc[ACC_WIDTH-1])) begin
        acc_next = acc[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
        sat_next = 1'b1;
      end else begin
        acc_next = sum_wrap;
      end
    end
  end
`else
  always_comb begin
    acc_next = sum_wrap;
    sat_next = sat;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      num_chunks <= '0;
      issued_cnt <= '0;
      recv_cnt   <= '0;
      valid_pipe <= '0;
      acc        <= '0;
      out_data   <= '0;
      sat        <= 1'b0;
    end else begin
      valid_pipe <= (valid_pipe << 1) | DP_LATENCY'(dp_issue);
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            num_chunks <= cmd_num_chunks;
            acc        <= '0;
            issued_cnt <= '0;
            recv_cnt   <= '0;
            sat        <= 1'b0;
            if (cmd_num_chunks == '0) begin
              out_data <= '0;
              state    <= S_OUT;
            end else begin
              state <= S_FEED;
            end
          end
        end
        S_FEED: begin
          if (dp_issue) begin
            issued_cnt <= issued_next;
            if (issued_next == num_chunks) state <= S_DRAIN;
          end
          if (tail) begin
            acc      <= acc_next;
            sat      <= sat_next;
            recv_cnt <= recv_next;
          end
        end
        S_DRAIN: begin
          if (tail) begin
            acc      <= acc_next;
            sat      <= sat_next;
            recv_cnt <= recv_next;
            if (recv_next == num_chunks) begin
              out_data <= acc_next;
              state    <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
